arm_waypoint_seq: RTL and testbench

Parametrised waypoint sequencer for the two-joint arm. It replaces hard-coded fixed-interval test sequencing with a writable table of up to DEPTH waypoints. Each waypoint carries a mode (angle or XY), two 32-bit operands, a catch flag and a dwell time in clock cycles. It drives the arm model's en1/en2/x/y/set_xita1/set_xita2/catch inputs, with start/stop, single-pass or looped playback, and status outputs.

---
 rtl/arm_waypoint_seq_if.sv | 45 ++++
 rtl/arm_waypoint_seq.sv | 174 +++++++++++++++++
 tb/tb_arm_waypoint_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_waypoint_seq_if.sv
// Bus bundle for the arm waypoint sequencer: table write port, playback
// control, arm-model drive outputs and status.
interface arm_waypoint_seq_if #(
  parameter int AW = 3,
  parameter int DW = 32,
  parameter int TW = 32
);
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic                 wr_mode;
  logic signed [DW-1:0] wr_a;
  logic signed [DW-1:0] wr_b;
  logic                 wr_catch;
  logic [TW-1:0]        wr_dwell;
  logic [AW:0]          num_pts;
  logic                 loop_en;
  logic                 start;
  logic                 stop;

  logic                 en1;
  logic                 en2;
  logic signed [DW-1:0] x;
  logic signed [DW-1:0] y;
  logic signed [DW-1:0] set_xita1;
  logic signed [DW-1:0] set_xita2;
  logic                 catch;
  logic                 busy;
  logic                 done;
  logic                 step;
  logic [AW-1:0]        cur_idx;

  modport master (
    output wr_en, wr_addr, wr_mode, wr_a, wr_b, wr_catch, wr_dwell,
    output num_pts, loop_en, start, stop,
    input  en1, en2, x, y, set_xita1, set_xita2, catch,
    input  busy, done, step, cur_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_mode, wr_a, wr_b, wr_catch, wr_dwell,
    input  num_pts, loop_en, start, stop,
    output en1, en2, x, y, set_xita1, set_xita2, catch,
    output busy, done, step, cur_idx
  );
endinterface

// File: rtl/arm_waypoint_seq.sv
// Waypoint sequencer for the two-joint arm: plays a writable table of
// angle/XY waypoints with per-entry dwell, single-pass or looped.
module arm_waypoint_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32,
  parameter int TW    = 32
) (
  input logic               clk,
  input logic               rst,
  arm_waypoint_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;

  // Waypoint table, no reset: contents survive rst
  logic                 mode_mem  [DEPTH];
  logic signed [DW-1:0] a_mem     [DEPTH];
  logic signed [DW-1:0] b_mem     [DEPTH];
  logic                 catch_mem [DEPTH];
  logic [TW-1:0]        dwell_mem [DEPTH];

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [AW:0]          neff_q, neff_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 en1_q, en1_d;
  logic                 en2_q, en2_d;
  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic signed [DW-1:0] xita1_q, xita1_d;
  logic signed [DW-1:0] xita2_q, xita2_d;
  logic                 catch_q, catch_d;
  logic                 done_q, done_d;
  logic                 step_q, step_d;
  logic [AW-1:0]        cur_idx_q, cur_idx_d;
  logic                 last_idx;

  function automatic logic [TW-1:0] dwell_floor(input logic [TW-1:0] d);
    return (d == '0) ? TW'(1) : d;
  endfunction

  function automatic logic [AW:0] count_sat(input logic [AW:0] n);
    return (n > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n;
  endfunction

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mode_mem[bus.wr_addr]  <= bus.wr_mode;
      a_mem[bus.wr_addr]     <= bus.wr_a;
      b_mem[bus.wr_addr]     <= bus.wr_b;
      catch_mem[bus.wr_addr] <= bus.wr_catch;
      dwell_mem[bus.wr_addr] <= bus.wr_dwell;
    end
  end

  assign last_idx = ({1'b0, idx_q} == (neff_q - 1'b1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    neff_d    = neff_q;
    cnt_d     = cnt_q;
    en1_d     = en1_q;
    en2_d     = en2_q;
    x_d       = x_q;
    y_d       = y_q;
    xita1_d   = xita1_q;
    xita2_d   = xita2_q;
    catch_d   = catch_q;
    cur_idx_d = cur_idx_q;
    step_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (count_sat(bus.num_pts) != '0)) begin
          neff_d  = count_sat(bus.num_pts);
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          // Table read is combinational, so a same-edge write is not seen here
          if (mode_mem[idx_q]) begin
            en1_d = 1'b1;
            en2_d = 1'b0;
            x_d   = a_mem[idx_q];
            y_d   = b_mem[idx_q];
          end else begin
            en1_d   = 1'b0;
            en2_d   = 1'b1;
            xita1_d = a_mem[idx_q];
            xita2_d = b_mem[idx_q];
          end
          catch_d   = catch_mem[idx_q];
          cur_idx_d = idx_q;
          step_d    = 1'b1;
          cnt_d     = dwell_floor(dwell_mem[idx_q]);
          state_d   = DWELL;
        end
      end
      DWELL: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == TW'(1)) begin
          if (!last_idx) begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end else if (bus.loop_en) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      neff_q    <= '0;
      cnt_q     <= '0;
      en1_q     <= 1'b0;
      en2_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      xita1_q   <= '0;
      xita2_q   <= '0;
      catch_q   <= 1'b0;
      cur_idx_q <= '0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      neff_q    <= neff_d;
      cnt_q     <= cnt_d;
      en1_q     <= en1_d;
      en2_q     <= en2_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xita1_q   <= xita1_d;
      xita2_q   <= xita2_d;
      catch_q   <= catch_d;
      cur_idx_q <= cur_idx_d;
      step_q    <= step_d;
      done_q    <= done_d;
    end
  end

  assign bus.en1       = en1_q;
  assign bus.en2       = en2_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.set_xita1 = xita1_q;
  assign bus.set_xita2 = xita2_q;
  assign bus.catch     = catch_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.step      = step_q;
  assign bus.cur_idx   = cur_idx_q;

endmodule

// File: tb/tb_arm_waypoint_seq.sv
// Directed bench for arm_waypoint_seq: hand-computed waypoint timing,
// looping, stop, edge counts, write/load ordering and async reset.
module tb_arm_waypoint_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int TW    = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  arm_waypoint_seq_if #(.AW(AW), .DW(DW), .TW(TW)) bus ();

  arm_waypoint_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int addr, input bit mode, input int a, input int b,
                          input bit c, input int dwell);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_mode  = mode;
    bus.wr_a     = a;
    bus.wr_b     = b;
    bus.wr_catch = c;
    bus.wr_dwell = TW'(dwell);
    tick();
    bus.wr_en    = 1'b0;
  endtask

  // Pulse start for one cycle and advance to the first step cycle (T+2)
  task automatic kick(input int npts, input bit lp);
    bus.num_pts = (AW+1)'(npts);
    bus.loop_en = lp;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    tick();
  endtask

  task automatic wait_step(input int budget, output int n, output int dones);
    n = 0;
    dones = 0;
    do begin
      tick();
      n++;
      if (bus.done) dones++;
    end while (!bus.step && n < budget);
  endtask

  task automatic wait_done(input string tag, input int budget, output int steps);
    int n;
    n = 0;
    steps = 0;
    do begin
      tick();
      n++;
      if (bus.step) steps++;
    end while (!bus.done && n < budget);
    chk(tag, bus.done, 1);
  endtask

  initial begin
    int n, d, s, dsum;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_mode = 1'b0;
    bus.wr_a = '0; bus.wr_b = '0; bus.wr_catch = 1'b0; bus.wr_dwell = '0;
    bus.num_pts = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    #1;
    chk("rst_en1", bus.en1, 0);
    chk("rst_en2", bus.en2, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_xita1", bus.set_xita1, 0);
    chk("rst_catch", bus.catch, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_cur_idx", bus.cur_idx, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    wr_entry(0, 1, 1276000, 0, 0, 10);
    wr_entry(1, 0, 0, 0, 1, 5);
    wr_entry(2, 1, 289057, 1639325, 0, 3);
    wr_entry(3, 0, 100, 200, 1, 0);

    // Single pass over 4 entries
    kick(4, 0);
    chk("p1_step0", bus.step, 1);
    chk("p1_en1", bus.en1, 1);
    chk("p1_en2", bus.en2, 0);
    chk("p1_x", bus.x, 1276000);
    chk("p1_idx0", bus.cur_idx, 0);
    chk("p1_busy", bus.busy, 1);
    wait_step(40, n, d);
    chk("p1_gap01", n, 11);
    chk("p1_e1_en2", bus.en2, 1);
    chk("p1_e1_en1", bus.en1, 0);
    chk("p1_e1_catch", bus.catch, 1);
    chk("p1_e1_x_hold", bus.x, 1276000);
    chk("p1_e1_idx", bus.cur_idx, 1);
    wait_step(40, n, d);
    chk("p1_gap12", n, 6);
    chk("p1_e2_x", bus.x, 289057);
    chk("p1_e2_y", bus.y, 1639325);
    chk("p1_e2_catch", bus.catch, 0);
    wait_step(40, n, d);
    chk("p1_gap23", n, 4);
    chk("p1_e3_xita1", bus.set_xita1, 100);
    chk("p1_e3_xita2", bus.set_xita2, 200);
    chk("p1_e3_idx", bus.cur_idx, 3);
    tick();
    chk("p1_done", bus.done, 1);
    chk("p1_busy_off", bus.busy, 0);
    tick();
    chk("p1_done_pulse", bus.done, 0);
    chk("p1_hold_en2", bus.en2, 1);
    chk("p1_hold_x", bus.x, 289057);
    chk("p1_hold_xita1", bus.set_xita1, 100);

    // Looped playback over 2 entries
    kick(2, 1);
    chk("lp_idx_a", bus.cur_idx, 0);
    dsum = 0;
    wait_step(40, n, d); dsum += d;
    chk("lp_gap_a", n, 11);
    chk("lp_idx_b", bus.cur_idx, 1);
    wait_step(40, n, d); dsum += d;
    chk("lp_gap_b", n, 6);
    chk("lp_idx_c", bus.cur_idx, 0);
    wait_step(40, n, d); dsum += d;
    chk("lp_gap_c", n, 11);
    chk("lp_idx_d", bus.cur_idx, 1);
    chk("lp_no_done", dsum, 0);

    // Stop mid-DWELL of entry 1
    repeat (2) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stp_busy", bus.busy, 0);
    chk("stp_en2", bus.en2, 1);
    chk("stp_catch", bus.catch, 1);
    chk("stp_done", bus.done, 0);
    dsum = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done || bus.busy) dsum++;
    end
    chk("stp_quiet", dsum, 0);
    kick(4, 0);
    chk("stp_restart_idx", bus.cur_idx, 0);
    chk("stp_restart_step", bus.step, 1);
    chk("stp_restart_en1", bus.en1, 1);
    wait_done("stp_run_done", 100, s);
    chk("stp_run_steps", s, 3);
    tick();

    // num_pts = 0 is ignored
    kick(0, 0);
    chk("np0_busy", bus.busy, 0);
    chk("np0_step", bus.step, 0);

    // start and stop together
    bus.stop = 1'b1;
    kick(4, 0);
    bus.stop = 1'b0;
    chk("ss_busy", bus.busy, 0);
    chk("ss_step", bus.step, 0);

    // num_pts beyond DEPTH plays exactly DEPTH entries
    for (int i = 4; i < DEPTH; i++) wr_entry(i, 1, 1000 + i, 2000 + i, i[0], 1);
    bus.num_pts = (AW+1)'(DEPTH + 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("ovr_done", 200, s);
    chk("ovr_steps", s, DEPTH);
    chk("ovr_idx", bus.cur_idx, DEPTH - 1);
    chk("ovr_x", bus.x, 1000 + DEPTH - 1);
    chk("ovr_y", bus.y, 2000 + DEPTH - 1);
    tick();

    // Write ordering against loads
    kick(4, 0);
    chk("wr_step0", bus.step, 1);
    repeat (10) tick();
    chk("wr_in_load", bus.step, 0);
    wr_entry(1, 0, 777, 888, 0, 5);
    chk("wr_e1_step", bus.step, 1);
    chk("wr_e1_old_xita1", bus.set_xita1, 0);
    chk("wr_e1_old_xita2", bus.set_xita2, 0);
    chk("wr_e1_old_catch", bus.catch, 1);
    wr_entry(2, 1, 4444, 5555, 1, 3);
    wait_step(40, n, d);
    chk("wr_e2_gap", n, 5);
    chk("wr_e2_x", bus.x, 4444);
    chk("wr_e2_y", bus.y, 5555);
    chk("wr_e2_catch", bus.catch, 1);
    wait_done("wr_done", 100, s);
    tick();

    // Async reset during DWELL, then replay from the kept table
    kick(4, 0);
    chk("ar_x", bus.x, 1276000);
    repeat (3) tick();
    rst = 1'b1;
    #2;
    chk("ar_en1", bus.en1, 0);
    chk("ar_x0", bus.x, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_catch", bus.catch, 0);
    rst = 1'b0;
    tick();
    chk("ar_idle", bus.busy, 0);
    kick(4, 0);
    chk("ar2_step", bus.step, 1);
    chk("ar2_x", bus.x, 1276000);
    wait_step(40, n, d);
    chk("ar2_gap", n, 11);
    chk("ar2_xita1", bus.set_xita1, 777);
    chk("ar2_xita2", bus.set_xita2, 888);
    chk("ar2_catch", bus.catch, 0);
    wait_done("ar2_done", 100, s);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
